// File: rtl/hs_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_tx_arbiter
// Brief    : Round-robin arbiter sharing one 4-phase req/ack link between
//            NUM_REQ requesters. Define HS_TIMEOUT_EN for the ack timeout/abort.
// Revision : 1.0 - initial release
// ============================================================================
module hs_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                       clka,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         done,
    output logic                       data_req,
    output logic [DATA_W-1:0]          data,
    input  logic                       data_ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || SYNC_STAGES < 2 || TIMEOUT < 2) begin : g_param_check
        $error("hs_tx_arbiter: parameter out of range");
    end

`ifdef HS_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;
    localparam int c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [c_idx_w-1:0]      ptr_q, ptr_d;
    logic [c_idx_w-1:0]      grant_q, grant_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    data_req_q, data_req_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;

    logic                    w_ack_s;
    logic                    w_found;
    logic [c_idx_w-1:0]      w_winner;
    logic [c_idx_w-1:0]      w_scan;
    logic [c_idx_w-1:0]      w_ptr_next;
    logic                    w_timeout;

    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], data_ack};
    assign w_ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign w_ptr_next = (grant_q == c_last_idx) ? '0 : grant_q + 1'b1;

    // First requester at or above the RR pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_scan = c_idx_w'((int'(ptr_q) + off) % NUM_REQ);
            if (!w_found && req_valid[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        data_req_d = data_req_q;
        req_ready  = '0;
        done       = '0;
        w_timeout  = 1'b0;
`ifdef HS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    grant_d             = w_winner;
                    data_d              = req_data[int'(w_winner)*DATA_W +: DATA_W];
                    state_d             = ST_SETUP;
                end
            end
            ST_SETUP: begin
                data_req_d = 1'b1;
                state_d    = ST_REQ_HI;
`ifdef HS_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            ST_REQ_HI: begin
                if (w_ack_s) begin
                    data_req_d = 1'b0;
                    state_d    = ST_REQ_LO;
`ifdef HS_TIMEOUT_EN
                end else if (cnt_q == c_cnt_last) begin
                    data_req_d = 1'b0;
                    w_timeout  = 1'b1;
                    ptr_d      = w_ptr_next;
                    cnt_d      = '0;
                    state_d    = ST_ABORT;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
`endif
                end
            end
            ST_REQ_LO: begin
                if (!w_ack_s) begin
                    done[grant_q] = 1'b1;
                    ptr_d         = w_ptr_next;
                    state_d       = ST_IDLE;
                end
            end
`ifdef HS_TIMEOUT_EN
            // A late ack must be seen low twice in a row before the link is reused.
            ST_ABORT: begin
                if (w_ack_s) begin
                    cnt_d = '0;
                end else if (cnt_q == c_cnt_w'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                data_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
        if (rst) begin
            req_ready = '0;
            done      = '0;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            data_req_q <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            data_req_q <= data_req_d;
            ack_sync_q <= ack_sync_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    always_ff @(posedge clka) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign err = w_timeout;
`else
    assign err = 1'b0;
`endif

    assign data_req = data_req_q;
    assign data     = data_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_tx_arbiter
// Brief    : Scoreboard bench for hs_tx_arbiter with a 4-phase receiver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 8;
`ifdef HS_TIMEOUT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        clka = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic        data_ack = 1'b0;
    logic [3:0]  req_ready;
    logic [3:0]  done;
    logic        data_req;
    logic [3:0]  data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err;

    always #5 clka = ~clka;

    hs_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clka     (clka),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .done     (done),
        .data_req (data_req),
        .data     (data),
        .data_ack (data_ack),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    typedef struct {
        bit         is_done;
        int         id;
        logic [3:0] dat;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] link_q[$];

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   err_cyc = 0;
    int   acc_cyc[4];
    int   hi_len = 0;
    int   last_hi_len = 0;
    bit   mon_en = 1'b0;
    bit   rx_en = 1'b1;
    int   ack_dly = 2;
    int   ack_hold = 1;
    logic [3:0] sticky = '0;
    logic [3:0] rdy_seen = '0;
    logic       prev_req = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_xfer(input int id, input logic [3:0] d, input bit with_done);
        ev_t e;
        e.is_done = 1'b0;
        e.id      = id;
        e.dat     = d;
        exp_q.push_back(e);
        if (with_done) begin
            e.is_done = 1'b1;
            exp_q.push_back(e);
            link_q.push_back(d);
        end
    endtask

    task automatic request(input logic [3:0] mask);
        @(posedge clka);
        #1;
        req_valid = req_valid | mask;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clka);
            #1;
            i++;
        end
        chk("wait_done_in_time", 32'(done_cnt >= target), 32'd1);
    endtask

    // Scoreboard monitor: pops the next expected event whenever the DUT pulses an output.
    always @(negedge clka) begin : mon
        ev_t e;
        cyc++;
        rdy_seen = req_ready;
        if (mon_en) begin
            if (req_ready !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 32'(req_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_kind", 32'(e.is_done), 32'd0);
                    chk("req_ready", 32'(req_ready), 32'd1 << e.id);
                    chk("accept_while_idle", 32'(busy), 32'd0);
                    acc_cyc[e.id] = cyc;
                end
            end
            if (done !== '0) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'd1);
                    chk("done", 32'(done), 32'd1 << e.id);
                    chk("done_data", 32'(data), 32'(e.dat));
                    chk("done_grant_id", 32'(grant_id), 32'(e.id));
                    chk("done_req_low", 32'(data_req), 32'd0);
                    chk("done_ack_low", 32'(data_ack), 32'd0);
                end
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (data_req === 1'b1 && prev_req === 1'b0) begin
                chk("setup_data_stable", 32'(data), 32'(prev_data));
            end
            if (busy === 1'b1 && prev_busy === 1'b1) begin
                chk("data_hold_while_busy", 32'(data), 32'(prev_data));
            end
            if (data_req === 1'b1) begin
                hi_len++;
            end else if (prev_req === 1'b1) begin
                last_hi_len = hi_len;
                hi_len      = 0;
            end
        end
        prev_req  = data_req;
        prev_busy = busy;
        prev_data = data;
    end

    // Requester model: a non-sticky requester drops valid right after its accept edge.
    always @(posedge clka) begin
        #1;
        req_valid = req_valid & ~(rdy_seen & ~sticky);
        rdy_seen  = '0;
    end

    // Receiver model in the far domain.
    initial begin : rx
        int n;
        forever begin
            @(negedge clka);
            if (rx_en && data_req === 1'b1) begin
                if (link_q.size() == 0) begin
                    chk("unexpected_link_req", 32'(data_req), 32'd0);
                end else begin
                    chk("link_data", 32'(data), 32'(link_q.pop_front()));
                end
                repeat (ack_dly) @(negedge clka);
                data_ack = 1'b1;
                n = 0;
                while (data_req === 1'b1 && n < 200) begin
                    @(negedge clka);
                    n++;
                end
                checks++;
                if (n > SYNC_STAGES + 1) begin
                    errors++;
                    $display("FAIL req_fall_latency: got %0d cycles, limit %0d", n, SYNC_STAGES + 1);
                end
                while (n < ack_hold) begin
                    @(negedge clka);
                    n++;
                end
                data_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int i;

        // Reset state
        repeat (3) @(posedge clka);
        #1 rst = 1'b0;
        @(negedge clka);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        mon_en = 1'b1;

        // Single transfer from requester 2
        req_data[11:8] = 4'hA;
        expect_xfer(2, 4'hA, 1'b1);
        request(4'b0100);
        wait_done(done_cnt + 1, 100);
        repeat (5) @(negedge clka);
        chk("req_low_after_done", 32'(data_req), 32'd0);

        // All four requesters valid from reset, then released after the first round
        @(posedge clka);
        #1;
        rst       = 1'b1;
        req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        sticky    = 4'hF;
        req_valid = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                expect_xfer(k, 4'(k + 1), 1'b1);
            end
        end
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        base = done_cnt;
        wait_done(base + 4, 300);
        sticky = '0;
        wait_done(base + 8, 300);

        // Fairness between requesters 0 and 3
        req_data = {4'hC, 4'h0, 4'h0, 4'h5};
        sticky   = 4'b1001;
        expect_xfer(0, 4'h5, 1'b1);
        expect_xfer(3, 4'hC, 1'b1);
        expect_xfer(0, 4'h5, 1'b1);
        expect_xfer(3, 4'hC, 1'b1);
        expect_xfer(0, 4'h5, 1'b1);
        base = done_cnt;
        request(4'b1001);
        wait_done(base + 3, 300);
        sticky = '0;
        wait_done(base + 5, 300);

        // Slow acknowledge held high for 20 cycles
        ack_hold      = 20;
        req_data[7:4] = 4'h7;
        expect_xfer(1, 4'h7, 1'b1);
        request(4'b0010);
        wait_done(done_cnt + 1, 200);
        ack_hold = 1;

        // Reset while in REQ_HI
        rx_en          = 1'b0;
        req_data[11:8] = 4'h9;
        expect_xfer(2, 4'h9, 1'b0);
        request(4'b0100);
        i = 0;
        while (data_req !== 1'b1 && i < 20) begin
            @(negedge clka);
            i++;
        end
        chk("reach_req_hi", 32'(data_req), 32'd1);
        @(posedge clka);
        #1 rst = 1'b1;
        @(posedge clka);
        #1 rst = 1'b0;
        @(negedge clka);
        #1;
        chk("midrst_data_req", 32'(data_req), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        rx_en = 1'b1;
        req_data[7:4]   = 4'h6;
        req_data[15:12] = 4'hB;
        expect_xfer(1, 4'h6, 1'b1);
        expect_xfer(3, 4'hB, 1'b1);
        base = done_cnt;
        request(4'b1010);
        wait_done(base + 2, 200);

`ifdef HS_TIMEOUT_EN
        // Acknowledge never arrives for requester 0
        rx_en         = 1'b0;
        req_data[3:0] = 4'hE;
        req_data[7:4] = 4'hD;
        expect_xfer(0, 4'hE, 1'b0);
        expect_xfer(1, 4'hD, 1'b1);
        request(4'b0011);
        i = 0;
        while (err_cnt < 1 && i < 100) begin
            @(negedge clka);
            #1;
            i++;
        end
        chk("err_seen", 32'(err_cnt), 32'd1);
        rx_en = 1'b1;
        @(negedge clka);
        #1;
        chk("timeout_req_len", 32'(last_hi_len), 32'(TIMEOUT));
        wait_done(done_cnt + 1, 200);
        chk("abort_to_next_accept", 32'(acc_cyc[1] - err_cyc), 32'd3);
`endif

        repeat (5) @(negedge clka);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("link_queue_empty", 32'(link_q.size()), 32'd0);
        chk("err_pulses", 32'(err_cnt), 32'(EXP_ERR));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
